// File: rtl/data_sram_bridge.sv
// MEM-stage data bus responder: splits each 32-bit access into up to two
// 16-bit req/ack SRAM transactions, stalling the pipeline until done.
module data_sram_bridge #(
    parameter int unsigned SRAM_AW  = 20,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_ce_i,
    input  logic               mem_we_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [3:0]         mem_sel_i,
    input  logic [31:0]        mem_data_i,
    output logic [31:0]        mem_data_o,
    output logic               stall_req_o,
    output logic               err_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [1:0]         sram_be_o,
    output logic [15:0]        sram_wdata_o,
    input  logic [15:0]        sram_rdata_i,
    input  logic               sram_ack_i
);

    localparam int unsigned AW_L  = SRAM_AW - 1;
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW_L-1:0]  addr_q, addr_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       half_be;
    logic [15:0]      half_rd;
    logic             txn_d;

    // Byte-offset bits and address bits above the SRAM range are not needed.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[31:SRAM_AW+1], mem_addr_i[1:0]};

    assign stall_req_o = rst && mem_ce_i && (state_q != DONE);

    // Next-state, latch and read-capture logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        err_flag_d = err_flag_q;
        cnt_d      = cnt_q;
        half_be    = (state_q == HI) ? sel_q[3:2] : sel_q[1:0];
        half_rd    = (sram_ack_i ? sram_rdata_i : 16'hFFFF)
                   & {{8{half_be[1]}}, {8{half_be[0]}}};

        case (state_q)
            IDLE: begin
                if (mem_ce_i) begin
                    addr_d     = mem_addr_i[SRAM_AW:2];
                    sel_d      = mem_sel_i;
                    we_d       = mem_we_i;
                    wdata_d    = mem_data_i;
                    rbuf_d     = '0;
                    err_flag_d = 1'b0;
                    cnt_d      = '0;
                    if (mem_sel_i[3:2] != 2'b00)      state_d = HI;
                    else if (mem_sel_i[1:0] != 2'b00) state_d = LO;
                    else                              state_d = DONE;
                end
            end
            HI, LO: begin
                // A timed-out half completes as if acked, reading all-ones.
                if (sram_ack_i || (cnt_q == CNT_W'(WAIT_MAX - 1))) begin
                    if (!we_q) begin
                        if (state_q == HI) rbuf_d[31:16] = half_rd;
                        else               rbuf_d[15:0]  = half_rd;
                    end
                    if (!sram_ack_i) err_flag_d = 1'b1;
                    cnt_d = '0;
                    if ((state_q == HI) && (sel_q[1:0] != 2'b00)) state_d = LO;
                    else                                          state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign txn_d = (state_d == HI) || (state_d == LO);

    // State and output registers; outputs derive from next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            err_flag_q   <= 1'b0;
            cnt_q        <= '0;
            sram_req_o   <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_be_o    <= '0;
            sram_wdata_o <= '0;
            mem_data_o   <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            err_flag_q   <= err_flag_d;
            cnt_q        <= cnt_d;
            sram_req_o   <= txn_d;
            sram_we_o    <= txn_d && we_d;
            sram_addr_o  <= txn_d ? {addr_d, (state_d == LO)} : '0;
            sram_be_o    <= (state_d == HI) ? sel_d[3:2] :
                            (state_d == LO) ? sel_d[1:0] : 2'b00;
            sram_wdata_o <= (state_d == HI) ? wdata_d[31:16] :
                            (state_d == LO) ? wdata_d[15:0]  : 16'h0000;
            mem_data_o   <= (state_d == DONE) ? rbuf_d : '0;
            err_o        <= (state_d == DONE) && err_flag_d;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: stimulus queues expected SRAM
// transactions and access completions; a monitor checks them as they appear.
module tb_data_sram_bridge;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        stall_req_o;
    logic        err_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [19:0] sram_addr_o;
    logic [1:0]  sram_be_o;
    logic [15:0] sram_wdata_o;
    logic [15:0] sram_rdata_i = '0;
    logic        sram_ack_i = 1'b0;

    data_sram_bridge #(.SRAM_AW(20), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .stall_req_o(stall_req_o), .err_o(err_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i), .sram_ack_i(sram_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          cycles;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          stalls;
    } done_t;

    txn_t  txn_q[$];
    done_t done_q[$];
    int    passed = 0;
    int    total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push_txn(input logic we, input logic [19:0] addr, input logic [1:0] be,
                            input logic [15:0] wdata, input int cycles);
        txn_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wdata; t.cycles = cycles;
        txn_q.push_back(t);
    endtask

    task automatic push_done(input logic [31:0] data, input logic err, input int stalls);
        done_t d;
        d.data = data; d.err = err; d.stalls = stalls;
        done_q.push_back(d);
    endtask

    // SRAM model: acks after sram_delay extra cycles, returns mem_arr contents.
    int               sram_delay = 0;
    logic [15:0]      mem_arr [int];
    bit               in_txn = 0;
    int               wait_left = 0;
    logic [19:0]      model_addr = '0;

    always @(posedge clk) begin
        logic acked;
        acked = sram_req_o && sram_ack_i;
        #1;
        if (acked) in_txn = 0;
        if (!sram_req_o) begin
            in_txn = 0;
        end else if (!in_txn || (sram_addr_o != model_addr)) begin
            in_txn = 1;
            model_addr = sram_addr_o;
            wait_left = sram_delay;
        end else if (wait_left > 0) begin
            wait_left--;
        end
        sram_ack_i = in_txn && (wait_left == 0);
        sram_rdata_i = (sram_ack_i && mem_arr.exists(int'(sram_addr_o)))
                     ? mem_arr[int'(sram_addr_o)] : 16'h0000;
    end

    // Monitor state.
    txn_t cur;
    int   cur_cycles = 0;
    bit   cur_stable = 1;
    int   stall_cnt = 0;
    bit   after_done = 0;

    task automatic finish_txn();
        txn_t e;
        if (txn_q.size() == 0) begin
            total++;
            $display("FAIL txn_unexpected: got addr 0x%0h be %b, want no transaction",
                     cur.addr, cur.be);
        end else begin
            e = txn_q.pop_front();
            chk("txn_we",     32'(cur.we),    32'(e.we));
            chk("txn_addr",   32'(cur.addr),  32'(e.addr));
            chk("txn_be",     32'(cur.be),    32'(e.be));
            chk("txn_wdata",  32'(cur.wdata), 32'(e.wdata));
            chk("txn_cycles", 32'(cur_cycles), 32'(e.cycles));
            chk("txn_stable", 32'(cur_stable), 32'd1);
        end
        cur_cycles = 0;
    endtask

    always @(negedge clk) begin
        done_t d;
        if (sram_req_o) begin
            if (cur_cycles == 0) begin
                cur.we = sram_we_o; cur.addr = sram_addr_o;
                cur.be = sram_be_o; cur.wdata = sram_wdata_o;
                cur_stable = 1;
            end else if ({sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o}
                         != {cur.we, cur.addr, cur.be, cur.wdata}) begin
                cur_stable = 0;
            end
            cur_cycles++;
            if (sram_ack_i || cur_cycles == WAIT_MAX) finish_txn();
        end else if (cur_cycles != 0) begin
            finish_txn();
        end

        if (!rst) begin
            stall_cnt = 0;
            after_done = 0;
        end else if (mem_ce_i) begin
            if (stall_req_o) begin
                stall_cnt++;
            end else if (done_q.size() == 0) begin
                total++;
                $display("FAIL done_unexpected: got data 0x%0h, want no completion", mem_data_o);
                stall_cnt = 0;
            end else begin
                d = done_q.pop_front();
                chk("done_data",   mem_data_o,       d.data);
                chk("done_err",    32'(err_o),       32'(d.err));
                chk("done_stalls", 32'(stall_cnt),   32'(d.stalls));
                stall_cnt = 0;
                after_done = 1;
            end
        end else if (after_done) begin
            chk("post_done_err",  32'(err_o), 32'd0);
            chk("post_done_data", mem_data_o, 32'd0);
            after_done = 0;
        end
    end

    task automatic access(input logic [31:0] addr, input logic [3:0] sel, input logic we,
                          input logic [31:0] data, input int delay);
        int n;
        @(posedge clk); #1;
        sram_delay = delay;
        mem_addr_i = addr; mem_sel_i = sel; mem_we_i = we; mem_data_i = data;
        mem_ce_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_req_o && n < 200);
        if (stall_req_o) begin
            total++;
            $display("FAIL access_timeout: stall high after %0d cycles, want low", n);
        end
        @(posedge clk); #1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_data_i = '0;
        @(posedge clk);
    endtask

    task automatic test_word_read();
        push_txn(1'b0, 20'h00080, 2'b11, 16'h0000, 1);
        push_txn(1'b0, 20'h00081, 2'b11, 16'h0000, 1);
        push_done(32'hDEADBEEF, 1'b0, 3);
        access(32'h0000_0100, 4'b1111, 1'b0, 32'h0, 0);
    endtask

    initial begin
        mem_arr[32'h80] = 16'hDEAD;
        mem_arr[32'h81] = 16'hBEEF;
        mem_arr[32'h20] = 16'h8001;
        mem_arr[32'h08] = 16'h12FF;

        // Reset values, with ce asserted to show it is ignored in reset.
        mem_ce_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   32'(sram_req_o),  32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_data",  mem_data_o,       32'd0);
        chk("rst_err",   32'(err_o),       32'd0);
        chk("rst_addr",  32'(sram_addr_o), 32'd0);
        mem_ce_i = 1'b0;
        #2 rst = 1'b1;

        test_word_read();

        // Byte write, LO half only.
        push_txn(1'b1, 20'h00101, 2'b01, 16'h5A5A, 1);
        push_done(32'h0, 1'b0, 2);
        access(32'h0000_0203, 4'b0001, 1'b1, 32'h5A5A5A5A, 0);

        // Halfword read with 4-cycle ack delay.
        push_txn(1'b0, 20'h00020, 2'b11, 16'h0000, 5);
        push_done(32'h80010000, 1'b0, 6);
        access(32'h0000_0040, 4'b1100, 1'b0, 32'h0, 4);

        // Byte read in the upper half: other byte masked off.
        push_txn(1'b0, 20'h00008, 2'b01, 16'h0000, 1);
        push_done(32'h00FF0000, 1'b0, 2);
        access(32'h0000_0010, 4'b0100, 1'b0, 32'h0, 0);

        // No ack: both halves time out.
        push_txn(1'b0, 20'h00040, 2'b11, 16'h0000, WAIT_MAX);
        push_txn(1'b0, 20'h00041, 2'b11, 16'h0000, WAIT_MAX);
        push_done(32'hFFFFFFFF, 1'b1, 1 + 2 * WAIT_MAX);
        access(32'h0000_0080, 4'b1111, 1'b0, 32'h0, 1000);

        // Empty byte select: no SRAM traffic.
        push_done(32'h0, 1'b0, 1);
        access(32'h0000_0010, 4'b0000, 1'b0, 32'h0, 0);

        // Word write with one wait cycle per half.
        push_txn(1'b1, 20'h00200, 2'b11, 16'h1122, 2);
        push_txn(1'b1, 20'h00201, 2'b11, 16'h3344, 2);
        push_done(32'h0, 1'b0, 5);
        access(32'h0000_0400, 4'b1111, 1'b1, 32'h11223344, 1);

        // Reset asserted during HI of a write.
        push_txn(1'b1, 20'h00300, 2'b11, 16'hCAFE, 2);
        @(posedge clk); #1;
        sram_delay = 100;
        mem_addr_i = 32'h0000_0600; mem_sel_i = 4'b1111; mem_we_i = 1'b1;
        mem_data_i = 32'hCAFEF00D; mem_ce_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req",   32'(sram_req_o),  32'd0);
        chk("midrst_we",    32'(sram_we_o),   32'd0);
        chk("midrst_stall", 32'(stall_req_o), 32'd0);
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_data_i = '0;
        @(negedge clk);
        #2 rst = 1'b1;

        test_word_read();

        repeat (3) @(posedge clk);
        chk("txn_queue_empty",  32'(txn_q.size()),  32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
